// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin arbiter/sequencer wrapped around an
// 8-bit gate-level ALU (module alu8, below).
// Optional feature macro: ALU_ARB_MULTIPASS_EN. When defined, shift ops
// iterate the ALU cnt+1 times. When undefined, every op is single-pass,
// req_cnt0/req_cnt1 are ignored and no pass counter exists.
//
// ALU select encoding (S[3:0]):
//   00xx arithmetic : D = A + Bx + Cin, Bx = {B, ~B, 8'h00, 8'hFF}[S1:S0]
//   01xx logic      : {A&B, A|B, A^B, ~A}[S1:S0]
//   1dxx shift      : d=0 logical left, d=1 logical right, zero fill
//   Z = (D == 0); Cout is the adder carry for arithmetic ops, 0 otherwise.

module alu8 (
  input  logic [3:0] i_s,
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  output logic [7:0] o_d,
  output logic       o_z,
  output logic       o_cout
);

  logic [7:0] w_bx;
  logic [7:0] w_p;
  logic [7:0] w_sum;
  logic [8:0] w_c;
  logic [7:0] w_log;
  logic [7:0] w_shl;
  logic [7:0] w_shr;
  logic [7:0] w_sh;
  logic       w_arith;
  logic       w_logic;

  assign w_c[0]  = i_cin;
  assign w_arith = ~i_s[3] & ~i_s[2];
  assign w_logic = ~i_s[3] &  i_s[2];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bit
      // B operand conditioning: pass, invert, force 0, force 1
      assign w_bx[gi] = (~i_s[1] & (i_b[gi] ^ i_s[0])) | (i_s[1] & i_s[0]);

      // Ripple-carry full adder cell
      assign w_p[gi]     = i_a[gi] ^ w_bx[gi];
      assign w_sum[gi]   = w_p[gi] ^ w_c[gi];
      assign w_c[gi + 1] = (i_a[gi] & w_bx[gi]) | (w_c[gi] & w_p[gi]);

      // Logic unit, one-hot decoded from S[1:0]
      assign w_log[gi] = (~i_s[1] & ~i_s[0] & (i_a[gi] & i_b[gi]))
                       | (~i_s[1] &  i_s[0] & (i_a[gi] | i_b[gi]))
                       | ( i_s[1] & ~i_s[0] & (i_a[gi] ^ i_b[gi]))
                       | ( i_s[1] &  i_s[0] & ~i_a[gi]);

      // Logical shifters: vacated bit is 0, nothing wraps
      if (gi == 0) begin : g_lsb
        assign w_shl[gi] = 1'b0;
      end else begin : g_nlsb
        assign w_shl[gi] = i_a[gi - 1];
      end
      if (gi == 7) begin : g_msb
        assign w_shr[gi] = 1'b0;
      end else begin : g_nmsb
        assign w_shr[gi] = i_a[gi + 1];
      end
      assign w_sh[gi] = (i_s[2] & w_shr[gi]) | (~i_s[2] & w_shl[gi]);

      // Result select by S[3:2]
      assign o_d[gi] = (w_arith & w_sum[gi])
                     | (w_logic & w_log[gi])
                     | (i_s[3]  & w_sh[gi]);
    end
  endgenerate

  assign o_z    = ~|o_d;
  assign o_cout = w_arith & w_c[8];

endmodule

module alu_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [3:0] req_op0,
  input  logic [3:0] req_op1,
  input  logic [7:0] req_a0,
  input  logic [7:0] req_a1,
  input  logic [7:0] req_b0,
  input  logic [7:0] req_b1,
  input  logic [1:0] req_cin,
  input  logic [2:0] req_cnt0,
  input  logic [2:0] req_cnt1,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_d,
  output logic       rsp_z,
  output logic       rsp_cout,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t     r_state;
  logic       r_rr_ptr;
  logic [3:0] r_op;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic       r_cin;
  logic       r_id;
  logic       r_rsp_valid;
  logic       r_rsp_id;
  logic [7:0] r_rsp_d;
  logic       r_rsp_z;
  logic       r_rsp_cout;

  logic       w_any_valid;
  logic       w_gnt_id;
  logic       w_accept;
  logic [3:0] w_sel_op;
  logic [7:0] w_sel_a;
  logic [7:0] w_sel_b;
  logic       w_sel_cin;
  logic [7:0] w_alu_d;
  logic       w_alu_z;
  logic       w_alu_cout;
  logic       w_more_passes;

`ifdef ALU_ARB_MULTIPASS_EN
  logic [2:0] r_cnt;
  logic [2:0] w_sel_cnt;

  assign w_sel_cnt     = w_gnt_id ? req_cnt1 : req_cnt0;
  // Another pass is needed only for shifts with passes still outstanding
  assign w_more_passes = r_op[3] & (r_cnt != 3'd0);
`else
  // Pass counts are meaningless when every op is single-pass
  logic w_unused_cnt;
  assign w_unused_cnt  = ^{req_cnt0, req_cnt1};
  assign w_more_passes = 1'b0;
`endif

  // Grant selection: a lone requester wins outright, a tie goes to r_rr_ptr
  assign w_any_valid = |req_valid;
  assign w_gnt_id    = (&req_valid) ? r_rr_ptr : req_valid[1];
  assign w_accept    = (r_state == ST_IDLE) & w_any_valid;

  // Accept strobe is one-hot and held low while reset is asserted
  assign req_ready = (w_accept & rst_n) ? (w_gnt_id ? 2'b10 : 2'b01) : 2'b00;

  // Payload of the granted requester
  assign w_sel_op  = w_gnt_id ? req_op1 : req_op0;
  assign w_sel_a   = w_gnt_id ? req_a1  : req_a0;
  assign w_sel_b   = w_gnt_id ? req_b1  : req_b0;
  assign w_sel_cin = w_gnt_id ? req_cin[1] : req_cin[0];

  alu8 u_alu (
    .i_s    (r_op),
    .i_a    (r_a),
    .i_b    (r_b),
    .i_cin  (r_cin),
    .o_d    (w_alu_d),
    .o_z    (w_alu_z),
    .o_cout (w_alu_cout)
  );

  // Sequencer FSM: arbitrate, run ALU passes, hold response until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= 1'b0;
      r_op        <= 4'h0;
      r_a         <= 8'h00;
      r_b         <= 8'h00;
      r_cin       <= 1'b0;
      r_id        <= 1'b0;
`ifdef ALU_ARB_MULTIPASS_EN
      r_cnt       <= 3'd0;
`endif
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_d     <= 8'h00;
      r_rsp_z     <= 1'b0;
      r_rsp_cout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_valid) begin
            r_op     <= w_sel_op;
            r_a      <= w_sel_a;
            r_b      <= w_sel_b;
            r_cin    <= w_sel_cin;
            r_id     <= w_gnt_id;
`ifdef ALU_ARB_MULTIPASS_EN
            r_cnt    <= w_sel_cnt;
`endif
            r_rr_ptr <= ~w_gnt_id;
            r_state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (w_more_passes) begin
            // Feed the shifted value back; B and Cin stay as latched
            r_a <= w_alu_d;
`ifdef ALU_ARB_MULTIPASS_EN
            r_cnt <= r_cnt - 3'd1;
`endif
          end else begin
            r_rsp_d     <= w_alu_d;
            r_rsp_z     <= w_alu_z;
            r_rsp_cout  <= w_alu_cout;
            r_rsp_id    <= r_id;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_d     = r_rsp_d;
  assign rsp_z     = r_rsp_z;
  assign rsp_cout  = r_rsp_cout;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: table of single transactions plus
// hand-written fairness, backpressure and reset-mid-op sequences.
// Expected values follow ALU_ARB_MULTIPASS_EN when it is defined.

module tb_alu_arbiter;

`ifdef ALU_ARB_MULTIPASS_EN
  localparam bit MP = 1'b1;
`else
  localparam bit MP = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [3:0] req_op0, req_op1;
  logic [7:0] req_a0, req_a1, req_b0, req_b1;
  logic [1:0] req_cin;
  logic [2:0] req_cnt0, req_cnt1;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_z, rsp_cout, busy;
  logic [7:0] rsp_d;

  int n_cmp = 0;
  int n_bad = 0;

  alu_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op0   (req_op0),
    .req_op1   (req_op1),
    .req_a0    (req_a0),
    .req_a1    (req_a1),
    .req_b0    (req_b0),
    .req_b1    (req_b1),
    .req_cin   (req_cin),
    .req_cnt0  (req_cnt0),
    .req_cnt1  (req_cnt1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_d     (rsp_d),
    .rsp_z     (rsp_z),
    .rsp_cout  (rsp_cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       id;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [2:0] cnt;
    logic [7:0] exp_d;
    logic       exp_z;
    logic       exp_c;
    logic       chk_f;
    int         passes;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mkv(logic id, logic [3:0] op, logic [7:0] a, logic [7:0] b,
                               logic cin, logic [2:0] cnt, logic [7:0] d,
                               logic z, logic c, logic f, int p);
    vec_t v;
    v.id = id; v.op = op; v.a = a; v.b = b; v.cin = cin; v.cnt = cnt;
    v.exp_d = d; v.exp_z = z; v.exp_c = c; v.chk_f = f; v.passes = p;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_payload(input logic id, input logic [3:0] op, input logic [7:0] a,
                             input logic [7:0] b, input logic cin, input logic [2:0] cnt);
    if (id) begin
      req_op1 = op; req_a1 = a; req_b1 = b; req_cin[1] = cin; req_cnt1 = cnt;
    end else begin
      req_op0 = op; req_a0 = a; req_b0 = b; req_cin[0] = cin; req_cnt0 = cnt;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One request/response transaction; starts and ends 1 time unit after a posedge
  task automatic run_op(input vec_t v, input int idx);
    int  n;
    bit  seen;
    logic [1:0] exp_rdy;
    exp_rdy = v.id ? 2'b10 : 2'b01;
    rsp_ready = 1'b1;
    set_payload(v.id, v.op, v.a, v.b, v.cin, v.cnt);
    req_valid = exp_rdy;
    seen = 1'b0;
    for (n = 0; n < 10; n++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        seen = 1'b1;
        break;
      end
    end
    chk($sformatf("v%0d_ready", idx), {30'd0, req_ready}, {30'd0, exp_rdy});
    if (!seen) return;
    @(posedge clk);
    #1 req_valid = 2'b00;
    seen = 1'b0;
    for (n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk($sformatf("v%0d_latency", idx), seen ? n : 0, v.passes);
    chk($sformatf("v%0d_d", idx), {24'd0, rsp_d}, {24'd0, v.exp_d});
    chk($sformatf("v%0d_id", idx), {31'd0, rsp_id}, {31'd0, v.id});
    if (v.chk_f) begin
      chk($sformatf("v%0d_z", idx), {31'd0, rsp_z}, {31'd0, v.exp_z});
      chk($sformatf("v%0d_cout", idx), {31'd0, rsp_cout}, {31'd0, v.exp_c});
    end
    $display("txn %0d: id=%0d op=%b a=%02h b=%02h cin=%0d cnt=%0d -> d=%02h z=%0d c=%0d passes=%0d",
             idx, v.id, v.op, v.a, v.b, v.cin, v.cnt, rsp_d, rsp_z, rsp_cout, n);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_drain", idx), {30'd0, rsp_valid, busy}, 32'd0);
  endtask

  task automatic wait_rsp(input string name, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_rsp_seen"}, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    bit ok;
    int gcnt, rcnt;
    int rem[2];
    logic gord[4];
    logic rord[4];
    logic [7:0] rd[4];
    logic [1:0] rdy_s;

    vecs[0]  = mkv(1'b0, 4'b0000, 8'h3C, 8'h05, 1'b0, 3'd0, 8'h41, 1'b0, 1'b0, 1'b1, 1);
    vecs[1]  = mkv(1'b1, 4'b0000, 8'hFF, 8'h01, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b1, 1);
    vecs[2]  = mkv(1'b0, 4'b0000, 8'h80, 8'h80, 1'b1, 3'd0, 8'h01, 1'b0, 1'b1, 1'b1, 1);
    vecs[3]  = mkv(1'b1, 4'b0001, 8'h50, 8'h20, 1'b1, 3'd0, 8'h30, 1'b0, 1'b1, 1'b1, 1);
    vecs[4]  = mkv(1'b0, 4'b0001, 8'h20, 8'h50, 1'b1, 3'd0, 8'hD0, 1'b0, 1'b0, 1'b1, 1);
    vecs[5]  = mkv(1'b1, 4'b0001, 8'h33, 8'h33, 1'b1, 3'd0, 8'h00, 1'b1, 1'b1, 1'b1, 1);
    vecs[6]  = mkv(1'b0, 4'b0010, 8'hFF, 8'h00, 1'b1, 3'd0, 8'h00, 1'b1, 1'b1, 1'b1, 1);
    vecs[7]  = mkv(1'b1, 4'b0011, 8'h01, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b1, 1);
    vecs[8]  = mkv(1'b0, 4'b0100, 8'hF0, 8'h3C, 1'b0, 3'd0, 8'h30, 1'b0, 1'b0, 1'b0, 1);
    vecs[9]  = mkv(1'b1, 4'b0101, 8'hF0, 8'h0F, 1'b0, 3'd0, 8'hFF, 1'b0, 1'b0, 1'b0, 1);
    vecs[10] = mkv(1'b0, 4'b0110, 8'hAA, 8'hFF, 1'b0, 3'd0, 8'h55, 1'b0, 1'b0, 1'b0, 1);
    vecs[11] = mkv(1'b1, 4'b0111, 8'h5A, 8'h00, 1'b0, 3'd0, 8'hA5, 1'b0, 1'b0, 1'b0, 1);
    vecs[12] = mkv(1'b0, 4'b1000, 8'h81, 8'h00, 1'b0, 3'd2, MP ? 8'h08 : 8'h02,
                   1'b0, 1'b0, 1'b0, MP ? 3 : 1);
    vecs[13] = mkv(1'b1, 4'b1100, 8'h80, 8'h00, 1'b0, 3'd6, MP ? 8'h01 : 8'h40,
                   1'b0, 1'b0, 1'b0, MP ? 7 : 1);
    vecs[14] = mkv(1'b0, 4'b1000, 8'h01, 8'h00, 1'b0, 3'd7, MP ? 8'h00 : 8'h02,
                   1'b0, 1'b0, 1'b0, MP ? 8 : 1);
    vecs[15] = mkv(1'b1, 4'b1101, 8'h03, 8'hFF, 1'b1, 3'd0, 8'h01, 1'b0, 1'b0, 1'b0, 1);
    vecs[16] = mkv(1'b0, 4'b0000, 8'h01, 8'h02, 1'b0, 3'd5, 8'h03, 1'b0, 1'b0, 1'b1, 1);

    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    req_cin = 2'b00;
    set_payload(1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 3'd0);
    set_payload(1'b1, 4'h0, 8'h00, 8'h00, 1'b0, 3'd0);

    // Reset state, with a request pending to show req_ready is forced low
    #2 req_valid = 2'b11;
    @(negedge clk);
    chk("rst_outputs", {19'd0, req_ready, rsp_valid, rsp_id, rsp_d, rsp_z, rsp_cout, busy}, 32'd0);
    req_valid = 2'b00;
    do_reset();

    for (int i = 0; i < 17; i++) run_op(vecs[i], i);

    // Fairness: both requesters valid with two ops each
    do_reset();
    rsp_ready = 1'b1;
    set_payload(1'b0, 4'b0000, 8'h01, 8'h01, 1'b0, 3'd0);
    set_payload(1'b1, 4'b0000, 8'h10, 8'h10, 1'b0, 3'd0);
    rem[0] = 2; rem[1] = 2;
    gcnt = 0; rcnt = 0;
    req_valid = 2'b11;
    for (int c = 0; c < 100 && rcnt < 4; c++) begin
      @(negedge clk);
      rdy_s = req_ready;
      if (rdy_s == 2'b11) chk("fair_ready_onehot", {30'd0, rdy_s}, 32'd1);
      if (rdy_s != 2'b00 && gcnt < 4) begin
        gord[gcnt] = rdy_s[1];
        gcnt++;
      end
      if (rsp_valid && rcnt < 4) begin
        rord[rcnt] = rsp_id;
        rd[rcnt] = rsp_d;
        rcnt++;
      end
      @(posedge clk);
      #1;
      for (int r = 0; r < 2; r++) begin
        if (rdy_s[r]) begin
          rem[r]--;
          if (rem[r] == 0) req_valid[r] = 1'b0;
        end
      end
    end
    chk("fair_grants", gcnt, 4);
    chk("fair_rsps", rcnt, 4);
    for (int k = 0; k < 4; k++) begin
      if (k < gcnt) chk($sformatf("fair_grant%0d", k), {31'd0, gord[k]}, k % 2);
      if (k < rcnt) begin
        chk($sformatf("fair_rspid%0d", k), {31'd0, rord[k]}, k % 2);
        chk($sformatf("fair_rspd%0d", k), {24'd0, rd[k]}, (k % 2 == 1) ? 32'h20 : 32'h02);
      end
    end
    $display("txn fairness: grants=%0d responses=%0d", gcnt, rcnt);
    req_valid = 2'b00;
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: hold the response while req1 waits
    rsp_ready = 1'b0;
    set_payload(1'b0, 4'b0000, 8'h3C, 8'h05, 1'b0, 3'd0);
    req_valid = 2'b01;
    @(negedge clk);
    chk("bp_ready0", {30'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 2'b00;
    wait_rsp("bp0", ok);
    req_valid = 2'b10;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", k),
          {19'd0, req_ready, rsp_valid, rsp_id, rsp_d, busy, 1'b0, 1'b0},
          {19'd0, 2'b00, 1'b1, 1'b0, 8'h41, 1'b1, 1'b0, 1'b0});
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_pre", {29'd0, req_ready, rsp_valid}, 32'b001);
    @(posedge clk);
    #1;
    chk("bp_idle", {30'd0, rsp_valid, busy}, 32'd0);
    @(negedge clk);
    chk("bp_ready1", {30'd0, req_ready}, 32'b10);
    @(posedge clk);
    #1;
    chk("bp_busy_after_accept", {31'd0, busy}, 32'd1);
    req_valid = 2'b00;
    wait_rsp("bp1", ok);
    chk("bp1_id_d", {23'd0, rsp_id, rsp_d}, {23'd0, 1'b1, 8'h20});
    $display("txn backpressure: second rsp id=%0d d=%02h", rsp_id, rsp_d);
    @(posedge clk);
    #1;

    // Reset mid-op: long shift interrupted during its third pass
    rsp_ready = 1'b0;
    set_payload(1'b0, 4'b1000, 8'h81, 8'h00, 1'b0, 3'd7);
    set_payload(1'b1, 4'b0000, 8'h10, 8'h10, 1'b0, 3'd0);
    req_valid = 2'b01;
    @(negedge clk);
    chk("rst_mid_ready", {30'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(posedge clk);
    @(posedge clk);
    #3;
    req_valid = 2'b11;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_async",
        {19'd0, req_ready, rsp_valid, rsp_id, rsp_d, rsp_z, rsp_cout, busy}, 32'd0);
    @(negedge clk);
    chk("rst_mid_held", {29'd0, req_ready, rsp_valid}, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_after_grant0", {29'd0, req_ready, rsp_valid}, 32'b010);
    @(posedge clk);
    #1 req_valid = 2'b10;
    rsp_ready = 1'b1;
    wait_rsp("rst_after", ok);
    chk("rst_after_rsp", {23'd0, rsp_id, rsp_d}, {23'd0, 1'b0, MP ? 8'h00 : 8'h02});
    $display("txn reset-mid-op: first rsp after reset id=%0d d=%02h", rsp_id, rsp_d);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_after_grant1", {30'd0, req_ready}, 32'b10);
    @(posedge clk);
    #1 req_valid = 2'b00;
    wait_rsp("rst_after1", ok);
    chk("rst_after1_rsp", {23'd0, rsp_id, rsp_d}, {23'd0, 1'b1, 8'h20});
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
